key_cmd_scheduler: RTL

Turns raw key events from the keyboard decoding path into sequenced game commands for the dino game core. It tracks which of the four game keys (enter, space, up, down) are held and runs the game-mode state machine. It auto-repeats jumps while a jump key is held and queues commands in a small FIFO drained by the game FSM over a valid/ready handshake. It sits between the keyboard value decoder and the game controller.

---
 rtl/key_cmd_scheduler_if.sv | 36 +++
 rtl/key_cmd_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_scheduler_if
//  Description : Bundles the key-event input, game status, the command
//                stream (valid/ready) and the scheduler status outputs.
//                The master side produces key events and consumes commands;
//                the slave side is the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_cmd_scheduler_if;
  // Key event strobe and its sampled payload
  logic       key_valid;
  logic [3:0] key_num;
  logic       key_pressed;
  // Level from the game core
  logic       game_over;
  // Command stream
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  // Status
  logic [1:0] mode;
  logic       duck;
  logic       overflow;

  modport master (
    output key_valid, key_num, key_pressed, game_over, cmd_ready,
    input  cmd_valid, cmd, mode, duck, overflow
  );

  modport slave (
    input  key_valid, key_num, key_pressed, game_over, cmd_ready,
    output cmd_valid, cmd, mode, duck, overflow
  );
endinterface
`default_nettype wire

// File: rtl/key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_scheduler
//  Description : Tracks the four game keys, runs the game-mode FSM,
//                auto-repeats jumps while a jump key is held and queues the
//                resulting commands in a small FIFO drained over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module key_cmd_scheduler #(
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int DEPTH         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_cmd_scheduler_if.slave   sched_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(REPEAT_CYCLES);
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] CMD_START  = 2'd0;
  localparam logic [1:0] CMD_JUMP   = 2'd1;
  localparam logic [1:0] CMD_PAUSE  = 2'd2;
  localparam logic [1:0] CMD_RESUME = 2'd3;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_PAUSE = 2'd2,
    MODE_OVER  = 2'd3
  } mode_e;

  // State registers
  mode_e          mode_q, mode_d;
  logic [3:0]     held_q, held_d;
  logic           rpt_on_q, rpt_on_d;
  logic [CW-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic           duck_q;
  logic           ovf_q;
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [1:0]     mem_q [DEPTH];

  // Key event decode
  logic       key_in_range;
  logic [1:0] key_idx;
  logic       key_fresh;
  logic       enter_fresh;
  logic       jump_held;
  logic       in_run;
  logic       jump_fresh;
  logic       rpt_tick;

  assign key_in_range = (sched_if.key_num[3:2] == 2'b00);
  assign key_idx      = sched_if.key_num[1:0];
  // A make on an already-held key is a typematic repeat, not a press.
  assign key_fresh    = sched_if.key_valid & sched_if.key_pressed & key_in_range
                        & ~held_q[key_idx];
  assign enter_fresh  = key_fresh & (key_idx == 2'd0);
  assign jump_held    = held_q[1] | held_q[2];
  assign in_run       = (mode_q == MODE_RUN);
  assign jump_fresh   = in_run & key_fresh & ((key_idx == 2'd1) | (key_idx == 2'd2))
                        & ~jump_held;
  assign rpt_tick     = in_run & rpt_on_q & jump_held & (rpt_cnt_q == '0);

  // Mode transitions and the mode command they generate
  logic       mode_push;
  logic [1:0] mode_cmd;

  // Next mode plus optional mode command; game_over beats enter while running.
  always_comb begin
    mode_d    = mode_q;
    mode_push = 1'b0;
    mode_cmd  = CMD_START;
    case (mode_q)
      MODE_IDLE: begin
        if (enter_fresh) begin
          mode_d    = MODE_RUN;
          mode_push = 1'b1;
          mode_cmd  = CMD_START;
        end
      end
      MODE_RUN: begin
        if (sched_if.game_over) begin
          mode_d = MODE_OVER;
        end else if (enter_fresh) begin
          mode_d    = MODE_PAUSE;
          mode_push = 1'b1;
          mode_cmd  = CMD_PAUSE;
        end
      end
      MODE_PAUSE: begin
        if (enter_fresh) begin
          mode_d    = MODE_RUN;
          mode_push = 1'b1;
          mode_cmd  = CMD_RESUME;
        end
      end
      default: begin
        if (enter_fresh) begin
          mode_d = MODE_IDLE;
        end
      end
    endcase
  end

  // One push per cycle at most: a mode command masks a coinciding repeat tick.
  logic       push_v;
  logic [1:0] push_cmd;
  assign push_v   = mode_push | jump_fresh | rpt_tick;
  assign push_cmd = mode_push ? mode_cmd : CMD_JUMP;

  // Held-key bitmap follows every in-range make/break regardless of mode.
  always_comb begin
    held_d = held_q;
    if (sched_if.key_valid && key_in_range) begin
      held_d[key_idx] = sched_if.key_pressed;
    end
  end

  // Repeat counter: armed only by a fresh jump, idles whenever jumping stops.
  always_comb begin
    rpt_on_d  = rpt_on_q;
    rpt_cnt_d = rpt_cnt_q;
    if (jump_fresh) begin
      rpt_on_d  = 1'b1;
      rpt_cnt_d = RPT_RELOAD;
    end else if (!in_run || !jump_held) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (rpt_on_q) begin
      rpt_cnt_d = (rpt_cnt_q == '0) ? RPT_RELOAD : (rpt_cnt_q - CW'(1));
    end
  end

  // FIFO status; the extra pointer bit separates full from empty.
  logic fifo_empty, fifo_full, fifo_pop, fifo_wr, fifo_drop;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = ~fifo_empty & sched_if.cmd_ready;
  assign fifo_wr    = push_v & (~fifo_full | fifo_pop);
  assign fifo_drop  = push_v & fifo_full & ~fifo_pop;

  // Control state: mode FSM, key tracking, repeat timer, pointers, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_IDLE;
      held_q    <= '0;
      rpt_on_q  <= 1'b0;
      rpt_cnt_q <= '0;
      duck_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      held_q    <= held_d;
      rpt_on_q  <= rpt_on_d;
      rpt_cnt_q <= rpt_cnt_d;
      duck_q    <= held_d[3] & (mode_d == MODE_RUN);
      if (fifo_drop) begin
        ovf_q <= 1'b1;
      end
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage array; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
    end
  end

  assign sched_if.cmd_valid = ~fifo_empty;
  assign sched_if.cmd       = fifo_empty ? 2'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign sched_if.mode      = mode_q;
  assign sched_if.duck      = duck_q;
  assign sched_if.overflow  = ovf_q;

endmodule
`default_nettype wire
